// File: rtl/mux_ldr_bus.sv
// Write-back source selector: picks RAM load data or ALU result, extracts and
// extends byte/halfword loads, and registers the value toward the register file.
module mux_ldr_bus #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] result,
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        addr_lo,
  input  logic              wb_en,
  input  logic [RD_W-1:0]   wb_rd_in,
  input  logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // The unselected source never reaches result, so X on it cannot leak through.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    result   = in2;
    if (in0) begin
      case (ld_size)
        2'b01: begin
          case (addr_lo)
            2'd0:    sel_byte = in1[7:0];
            2'd1:    sel_byte = in1[15:8];
            2'd2:    sel_byte = in1[23:16];
            default: sel_byte = in1[31:24];
          endcase
          result = {{24{ld_signed & sel_byte[7]}}, sel_byte};
        end
        2'b10: begin
          // Misaligned halfword (addr_lo[0]=1) is silently rounded down to its lane.
          sel_half = addr_lo[1] ? in1[31:16] : in1[15:0];
          result   = {{16{ld_signed & sel_half[15]}}, sel_half};
        end
        default: result = in1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else if (!stall) begin
      wb_valid <= wb_en;
      wb_data  <= result;
      wb_rd    <= wb_rd_in;
    end
  end

endmodule

// File: tb/tb_mux_ldr_bus.sv
// Directed self-checking bench for mux_ldr_bus: load extraction, ALU bypass,
// write-back latency, stall hold and asynchronous reset.
module tb_mux_ldr_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in0;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] result;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  addr_lo;
  logic        wb_en;
  logic [3:0]  wb_rd_in;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  mux_ldr_bus #(.DATA_W(32), .RD_W(4)) dut (
    .in0(in0), .in1(in1), .in2(in2), .result(result),
    .clk(clk), .rst_n(rst_n),
    .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
    .wb_en(wb_en), .wb_rd_in(wb_rd_in), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic sel, input logic [31:0] ram, input logic [31:0] alu,
                               input logic [1:0] sz, input logic sgn, input logic [1:0] lo);
    in0       = sel;
    in1       = ram;
    in2       = alu;
    ld_size   = sz;
    ld_signed = sgn;
    addr_lo   = lo;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkWb(input string tag, input logic v, input logic [31:0] d, input logic [3:0] r);
    checkOutput({tag, "_valid"}, {31'd0, wb_valid}, {31'd0, v});
    checkOutput({tag, "_data"}, wb_data, d);
    checkOutput({tag, "_rd"}, {28'd0, wb_rd}, {28'd0, r});
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_en    = 1'b0;
    wb_rd_in = 4'd0;
    stall    = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0);
    #3;
    checkWb("reset_state", 1'b0, 32'h0, 4'd0);

    // Combinational selection and extraction, checked while still in reset.
    applyStimulus(1'b1, 32'h00000000, 32'h00000007, 2'b00, 1'b0, 2'd0);
    checkOutput("word_ram0", result, 32'h00000000);
    applyStimulus(1'b0, 32'h00000001, 32'h83240324, 2'b00, 1'b0, 2'd0);
    checkOutput("word_alu0", result, 32'h83240324);
    applyStimulus(1'b1, 32'h00C2569C, 32'hC256C256, 2'b00, 1'b0, 2'd0);
    checkOutput("word_ram1", result, 32'h00C2569C);
    applyStimulus(1'b0, 32'h00003246, 32'h41254125, 2'b00, 1'b0, 2'd0);
    checkOutput("word_alu1", result, 32'h41254125);
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b11, 1'b1, 2'd1);
    checkOutput("size11_word", result, 32'h00C2569C);

    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b1, 2'd0);
    checkOutput("byte0_signed", result, 32'hFFFFFF9C);
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b0, 2'd0);
    checkOutput("byte0_unsigned", result, 32'h0000009C);
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b1, 2'd1);
    checkOutput("byte1_signed", result, 32'h00000056);
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b1, 2'd2);
    checkOutput("byte2_signed", result, 32'h000000C2 | 32'hFFFFFF00);
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b1, 2'd3);
    checkOutput("byte3_signed", result, 32'h00000000);

    applyStimulus(1'b1, 32'h83240324, 32'h0, 2'b10, 1'b1, 2'd2);
    checkOutput("half_hi_signed", result, 32'hFFFF8324);
    applyStimulus(1'b1, 32'h83240324, 32'h0, 2'b10, 1'b1, 2'd3);
    checkOutput("half_hi_misaligned", result, 32'hFFFF8324);
    applyStimulus(1'b1, 32'h83240324, 32'h0, 2'b10, 1'b0, 2'd2);
    checkOutput("half_hi_unsigned", result, 32'h00008324);
    applyStimulus(1'b1, 32'h83240324, 32'h0, 2'b10, 1'b0, 2'd0);
    checkOutput("half_lo_unsigned", result, 32'h00000324);

    applyStimulus(1'b0, 32'h00C2569C, 32'hC256C256, 2'b01, 1'b1, 2'd3);
    checkOutput("alu_bypass", result, 32'hC256C256);
    applyStimulus(1'b0, 32'hXXXXXXXX, 32'h12345678, 2'b00, 1'b0, 2'd0);
    checkOutput("alu_x_ram", result, 32'h12345678);

    // Registers stay cleared across an edge while reset is held.
    @(posedge clk); #1;
    checkWb("held_in_reset", 1'b0, 32'h0, 4'd0);

    @(negedge clk);
    rst_n    = 1'b1;
    wb_en    = 1'b1;
    wb_rd_in = 4'd5;
    applyStimulus(1'b0, 32'h0, 32'h83240324, 2'b00, 1'b0, 2'd0);
    checkWb("before_edge", 1'b0, 32'h0, 4'd0);
    @(posedge clk); #1;
    checkWb("wb_first", 1'b1, 32'h83240324, 4'd5);

    @(negedge clk);
    stall    = 1'b1;
    wb_en    = 1'b0;
    wb_rd_in = 4'd9;
    applyStimulus(1'b1, 32'h00C2569C, 32'h0, 2'b01, 1'b0, 2'd1);
    checkOutput("stall_result_live", result, 32'h00000056);
    @(posedge clk); #1;
    checkWb("stall_hold1", 1'b1, 32'h83240324, 4'd5);
    @(posedge clk); #1;
    checkWb("stall_hold2", 1'b1, 32'h83240324, 4'd5);

    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    checkWb("unstall", 1'b0, 32'h00000056, 4'd9);

    // Back-to-back captures, one per cycle.
    wb_en    = 1'b1;
    wb_rd_in = 4'd3;
    applyStimulus(1'b0, 32'h0, 32'hAAAA5555, 2'b00, 1'b0, 2'd0);
    @(posedge clk); #1;
    checkWb("b2b_a", 1'b1, 32'hAAAA5555, 4'd3);
    wb_rd_in = 4'd12;
    applyStimulus(1'b1, 32'h83240324, 32'h0, 2'b10, 1'b1, 2'd2);
    @(posedge clk); #1;
    checkWb("b2b_b", 1'b1, 32'hFFFF8324, 4'd12);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkWb("async_reset", 1'b0, 32'h0, 4'd0);
    applyStimulus(1'b0, 32'h0, 32'h0BADF00D, 2'b00, 1'b0, 2'd0);
    checkOutput("reset_result_live", result, 32'h0BADF00D);

    // Reset asserted during a stall clears the held value.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkWb("after_reset_capture", 1'b1, 32'h0BADF00D, 4'd12);
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkWb("reset_mid_stall", 1'b0, 32'h0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkWb("stall_after_reset", 1'b0, 32'h0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
